// File: rtl/md5_padder.sv
// ============================================================================
//  Module      : md5_padder
//  Description : MD5 message padder and block builder. Packs a byte stream
//                into 512-bit blocks and applies MD5 padding: the 0x80 marker,
//                zero fill and the 64-bit little-endian bit length.
//                Optional feature macro: MD5_PADDER_FIRST_EN adds a blk_first
//                output that flags the first block of each message.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md5_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last
`ifdef MD5_PADDER_FIRST_EN
    ,
    output logic         blk_first
`endif
);

    typedef enum logic [2:0] {
        S_FILL = 3'd0,
        S_PAD  = 3'd1,
        S_FIN  = 3'd2,
        S_OUT  = 3'd3,
        S_OUT2 = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_alive;    // low only while in reset; gates in_ready
    logic [511:0]       r_data;
    logic [5:0]         r_idx;
    logic [LEN_W-1:0]   r_bitlen;
    logic               r_valid;
    logic               r_last;
    logic               r_full;     // byte 63 was written by the data stream
    logic               r_pend;     // marker still owed after a full data block
    logic               r_out2;     // length-only block follows the current one

    logic               w_accept;
    logic               w_write;
    logic               w_next_out;
    logic [63:0]        w_len64;

    assign w_accept   = in_valid & in_ready;
    assign w_write    = w_accept & ~in_empty;
    assign w_next_out = (w_next == S_OUT) || (w_next == S_OUT2);
    assign w_len64    = 64'(r_bitlen);

    assign in_ready   = r_alive & (r_state == S_FILL);
    assign blk_valid  = r_valid;
    assign blk_data   = r_data;
    assign blk_last   = r_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL: begin
                if (w_accept && in_last) begin
                    w_next = S_PAD;
                end else if (w_write && (r_idx == 6'd63)) begin
                    w_next = S_OUT;
                end
            end
            S_PAD:  w_next = r_full ? S_OUT : S_FIN;
            S_FIN:  w_next = S_OUT;
            S_OUT: begin
                if (blk_ready) begin
                    if (r_last) begin
                        w_next = S_FILL;
                    end else if (r_pend) begin
                        w_next = S_PAD;
                    end else if (r_out2) begin
                        w_next = S_OUT2;
                    end else begin
                        w_next = S_FILL;
                    end
                end
            end
            S_OUT2: begin
                if (blk_ready) begin
                    w_next = S_FILL;
                end
            end
            default: w_next = S_FILL;
        endcase
    end

    // Block buffer, byte index, bit counter and block flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive  <= 1'b0;
            r_data   <= '0;
            r_idx    <= '0;
            r_bitlen <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_full   <= 1'b0;
            r_pend   <= 1'b0;
            r_out2   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_valid <= w_next_out;
            case (r_state)
                S_FILL: begin
                    if (w_write) begin
                        r_data[8*r_idx +: 8] <= in_data;
                        r_idx                <= r_idx + 6'd1;
                        r_bitlen             <= r_bitlen + LEN_W'(8);
                        if (r_idx == 6'd63) begin
                            r_full <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    // A full data block leaves no room: ship it and place
                    // the marker at byte 0 of the next block.
                    r_last <= 1'b0;
                    if (r_full) begin
                        r_pend <= 1'b1;
                    end else begin
                        r_data[8*r_idx +: 8] <= 8'h80;
                    end
                end
                S_FIN: begin
                    for (int i = 0; i < 64; i++) begin
                        if (i > int'(r_idx)) begin
                            r_data[8*i +: 8] <= 8'h00;
                        end
                    end
                    if (r_idx <= 6'd55) begin
                        r_data[511:448] <= w_len64;
                        r_last          <= 1'b1;
                    end else begin
                        r_last <= 1'b0;
                        r_out2 <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (blk_ready) begin
                        r_data <= '0;
                        r_idx  <= '0;
                        r_full <= 1'b0;
                        r_pend <= 1'b0;
                        if (r_last) begin
                            r_bitlen <= '0;
                            r_last   <= 1'b0;
                        end else if (!r_pend && r_out2) begin
                            r_data[511:448] <= w_len64;
                            r_last          <= 1'b1;
                            r_out2          <= 1'b0;
                        end
                    end
                end
                S_OUT2: begin
                    if (blk_ready) begin
                        r_data   <= '0;
                        r_idx    <= '0;
                        r_bitlen <= '0;
                        r_last   <= 1'b0;
                        r_out2   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MD5_PADDER_FIRST_EN
    logic r_first;
    logic r_msg_first;      // next block produced starts a new message
    logic w_msg_first_nxt;

    assign w_msg_first_nxt = (r_valid & blk_ready) ? r_last : r_msg_first;
    assign blk_first       = r_first;

    // First-block flag, loaded alongside the block it describes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first     <= 1'b0;
            r_msg_first <= 1'b1;
        end else begin
            r_msg_first <= w_msg_first_nxt;
            r_first     <= w_msg_first_nxt & w_next_out;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_md5_padder.sv
// ============================================================================
//  Module      : tb_md5_padder
//  Description : Self-checking scoreboard bench for md5_padder. Expected
//                blocks are queued when a message is issued; a monitor pops
//                and compares on every block transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md5_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         in_empty = 1'b0;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic [511:0] blk_data;
    logic         blk_last;
`ifdef MD5_PADDER_FIRST_EN
    logic         blk_first;
`endif

    md5_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
`ifdef MD5_PADDER_FIRST_EN
        ,
        .blk_first (blk_first)
`endif
    );

    always #5 clk = ~clk;

    logic [511:0] exp_data_q [$];
    bit           exp_last_q [$];
    bit           exp_first_q [$];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           n_rx = 0;
    int           target = 0;
    logic [511:0] rx_data = '0;
    logic [7:0]   msg [0:127];

    task automatic chk(input string name, input logic [519:0] got, input logic [519:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: compare every transferred block against the scoreboard
    always @(negedge clk) begin
        if (rst_n && blk_valid && blk_ready) begin
            rx_data = blk_data;
            n_rx++;
            if (exp_data_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_block: got %0h expected none", blk_data);
            end else begin
                chk("blk_data", 520'(blk_data), 520'(exp_data_q.pop_front()));
                chk("blk_last", 520'(blk_last), 520'(exp_last_q.pop_front()));
`ifdef MD5_PADDER_FIRST_EN
                chk("blk_first", 520'(blk_first), 520'(exp_first_q.pop_front()));
`else
                void'(exp_first_q.pop_front());
`endif
            end
        end
    end

    task automatic fill_msg(input int n, input logic [7:0] seed);
        for (int i = 0; i < n; i++) msg[i] = seed + 8'(i * 7);
    endtask

    // Reference padding: msg || 80 || 00.. || LE64(bitlen), cut into blocks
    task automatic push_expected(input int n);
        logic [7:0]   p [0:191];
        logic [63:0]  bl;
        logic [511:0] d;
        int           len;
        len = ((n + 9 + 63) / 64) * 64;
        for (int i = 0; i < 192; i++) p[i] = 8'h00;
        for (int i = 0; i < n; i++) p[i] = msg[i];
        p[n] = 8'h80;
        bl = 64'(n) * 64'd8;
        for (int k = 0; k < 8; k++) p[len-8+k] = bl[8*k +: 8];
        for (int b = 0; b < len / 64; b++) begin
            d = '0;
            for (int j = 0; j < 64; j++) d[8*j +: 8] = p[64*b + j];
            exp_data_q.push_back(d);
            exp_last_q.push_back(b == len / 64 - 1);
            exp_first_q.push_back(b == 0);
            target++;
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 300);
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic send_msg(input int n, input bit do_last);
        for (int i = 0; i < n; i++) send_beat(msg[i], do_last && (i == n - 1), 1'b0);
        if (n == 0 && do_last) send_beat(8'h00, 1'b1, 1'b1);
    endtask

    task automatic wait_rx();
        int t;
        t = 0;
        while (n_rx < target && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (n_rx < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_timeout: got %0d expected %0d", n_rx, target);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic         v0, v1, v2;
        logic [511:0] hold_d;
        logic         hold_l;
        int           t;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 520'(in_ready), 520'(0));
        chk("rst_blk_valid", 520'(blk_valid), 520'(0));
        chk("rst_blk_last", 520'(blk_last), 520'(0));
        chk("rst_blk_data", 520'(blk_data), 520'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 520'(in_ready), 520'(1));

        // Empty message
        push_expected(0);
        send_msg(0, 1'b1);
        wait_rx();
        chk("empty_byte0", 520'(rx_data[7:0]), 520'(8'h80));

        // "abc" with latency check on the final beat
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        push_expected(3);
        send_beat(8'h61, 1'b0, 1'b0);
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'h63, 1'b1, 1'b0);
        @(negedge clk); v0 = blk_valid;
        @(negedge clk); v1 = blk_valid;
        @(negedge clk); v2 = blk_valid;
        chk("last_latency", 520'({v0, v1, v2}), 520'(3'b001));
        wait_rx();
        chk("abc_word0", 520'(rx_data[31:0]), 520'(32'h80636261));
        chk("abc_len", 520'(rx_data[511:448]), 520'(64'h18));

        // "abc" with an ignored empty non-last beat in the middle
        push_expected(3);
        send_beat(8'h61, 1'b0, 1'b0);
        send_beat(8'h5A, 1'b0, 1'b1);
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'h63, 1'b1, 1'b0);
        wait_rx();

        // 55 bytes: marker and length share one block
        fill_msg(55, 8'h11);
        push_expected(55);
        send_msg(55, 1'b1);
        wait_rx();
        chk("len55_marker", 520'(rx_data[8*55 +: 8]), 520'(8'h80));
        chk("len55_len", 520'(rx_data[8*56 +: 16]), 520'(16'h01B8));

        // 56 bytes: length spills to a second block
        fill_msg(56, 8'h23);
        push_expected(56);
        send_msg(56, 1'b1);
        wait_rx();
        chk("len56_len", 520'(rx_data[8*56 +: 16]), 520'(16'h01C0));
        chk("len56_zero", 520'(rx_data[447:0]), 520'(0));

        // 64 bytes: marker opens the second block
        fill_msg(64, 8'h35);
        push_expected(64);
        send_msg(64, 1'b1);
        wait_rx();
        chk("len64_marker", 520'(rx_data[7:0]), 520'(8'h80));
        chk("len64_len", 520'(rx_data[8*56 +: 16]), 520'(16'h0200));

        // Backpressure: block held for 10 cycles, then one transfer
        blk_ready = 1'b0;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        push_expected(3);
        send_msg(3, 1'b1);
        t = 0;
        while (!blk_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        hold_d = blk_data;
        hold_l = blk_last;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", {5'd0, blk_valid, in_ready, blk_last, blk_data},
                {5'd0, 1'b1, 1'b0, hold_l, hold_d});
        end
        @(posedge clk);
        #1;
        blk_ready = 1'b1;
        wait_rx();
        repeat (5) @(negedge clk);
        chk("bp_one_xfer", 520'(n_rx), 520'(target));

        // Reset mid-message, then "abc"
        fill_msg(30, 8'h47);
        send_msg(30, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 520'(in_ready), 520'(0));
        chk("midrst_blk_valid", 520'(blk_valid), 520'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        push_expected(3);
        send_msg(3, 1'b1);
        wait_rx();
        chk("midrst_abc_word0", 520'(rx_data[31:0]), 520'(32'h80636261));

        // Two back-to-back 64-byte messages
        fill_msg(64, 8'h02);
        push_expected(64);
        send_msg(64, 1'b1);
        fill_msg(64, 8'h91);
        push_expected(64);
        send_msg(64, 1'b1);
        wait_rx();

        repeat (20) @(negedge clk);
        chk("rx_count", 520'(n_rx), 520'(target));
        chk("queue_empty", 520'(exp_data_q.size()), 520'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
